uart_block_assembler: RTL and testbench



---
 rtl/uart_blk_pkg.sv | 21 ++
 rtl/uart_block_assembler_fifo.sv | 67 ++++++
 rtl/uart_block_assembler.sv | 198 +++++++++++++++++++
 tb/tb_uart_block_assembler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_blk_pkg.sv
// uart_blk_pkg
// Shared definitions for the UART block assembler: parser state encoding,
// default start-of-frame marker, command bit positions and block geometry.
package uart_blk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } blk_state_t;

  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         CMD_INIT_BIT    = 0;
  localparam int         WORDS_PER_BLOCK = 16;
  localparam int         BYTES_PER_BLOCK = 64;

  // FIFO entry layout: {sob, init, eob, word[31:0]}
  localparam int         ENTRY_W         = 35;

endpackage

// File: rtl/uart_block_assembler_fifo.sv
// sync_word_fifo
// Single-clock FIFO holding packed words plus sideband flags.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write request (dropped when full unless i_pop is also taken)
//   i_data    : write data
//   i_pop     : read request (ignored while empty)
//   o_data    : head entry, driven from the storage registers
//   o_full    : occupancy == DEPTH
//   o_empty   : occupancy == 0
//   o_count   : occupancy, $clog2(DEPTH)+1 bits
module sync_word_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop     = i_pop && !o_empty;
  // A push into a full FIFO is still taken when the head leaves the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/uart_block_assembler.sv
// uart_block_assembler
// Parses framed host commands from the UART byte stream
// (SOF, CMD, 64 payload bytes [, CSUM]), packs payload big-endian into
// 32-bit words and queues them with per-block flags for the SHA-256 core.
// Optional feature macro: BLOCK_CSUM_EN adds a trailing XOR checksum byte.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   rx_data/rx_valid  : byte stream, one-cycle strobe, cannot be stalled
//   word_data         : packed word at FIFO head
//   word_valid        : FIFO non-empty
//   word_ready        : consumer accepts
//   word_sob/init/eob : block start / INIT flag / block end for head word
//   blk_done, blk_err : one-cycle frame completion / abort pulses
//   ovf               : sticky word-drop flag, cleared by next accepted SOF
//   dbg_state         : current parser state
//   dbg_fifo_count    : current FIFO occupancy
// Handshake: a word transfers on every clock edge where word_valid and
// word_ready are both 1; while word_valid=1 and word_ready=0 the head word
// and its flags do not change, and word_valid does not drop.
module uart_block_assembler
  import uart_blk_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [31:0]                  word_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         word_sob,
  output logic                         word_init,
  output logic                         word_eob,
  output logic                         blk_done,
  output logic                         blk_err,
  output logic                         ovf,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]  dbg_fifo_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  blk_state_t         r_state;
  blk_state_t         w_next;
  logic [5:0]         r_byte_cnt;
  logic [23:0]        r_pack;
  logic               r_init;
  logic [TW-1:0]      r_to_cnt;
  logic               r_ovf;
`ifdef BLOCK_CSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_push;
  logic               w_done;
  logic               w_err;
  logic               w_sof;
  logic               w_timeout;
  logic               w_last;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [3:0]         w_word_idx;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;
  logic [CW-1:0]      w_count;

  assign w_word_idx = r_byte_cnt[5:2];
  assign w_last     = (r_byte_cnt == 6'(BYTES_PER_BLOCK - 1));
  // The counter sits at TIMEOUT_CYC-1 after that many silent cycles; the
  // next silent cycle is the one that reaches the limit.
  assign w_timeout  = (r_state != ST_IDLE) && !rx_valid &&
                      (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_pop      = word_valid && word_ready;
  // Current byte completes the word; the three earlier bytes sit in r_pack.
  assign w_din      = {(w_word_idx == 4'd0), r_init,
                       (w_word_idx == 4'(WORDS_PER_BLOCK - 1)),
                       r_pack, rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    w_sof  = 1'b0;
    if (w_timeout) begin
      w_next = ST_IDLE;
      w_err  = 1'b1;
    end else if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SOF_BYTE) begin
            w_next = ST_CMD;
            w_sof  = 1'b1;
          end
        end
        ST_CMD: w_next = ST_PAYLOAD;
        ST_PAYLOAD: begin
          w_push = (r_byte_cnt[1:0] == 2'd3);
          if (w_last) begin
`ifdef BLOCK_CSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_IDLE;
            w_done = 1'b1;
`endif
          end
        end
`ifdef BLOCK_CSUM_EN
        ST_CSUM: begin
          w_next = ST_IDLE;
          if (rx_data == r_csum) w_done = 1'b1;
          else                   w_err  = 1'b1;
        end
`endif
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_pack     <= '0;
      r_init     <= 1'b0;
      r_to_cnt   <= '0;
      r_ovf      <= 1'b0;
`ifdef BLOCK_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      if (r_state == ST_IDLE || rx_valid || w_timeout) r_to_cnt <= '0;
      else                                              r_to_cnt <= r_to_cnt + TW'(1);

      if (w_timeout) begin
        r_byte_cnt <= '0;
        r_pack     <= '0;
      end else if (rx_valid) begin
        case (r_state)
          ST_CMD: begin
            r_init     <= rx_data[CMD_INIT_BIT];
            r_byte_cnt <= '0;
`ifdef BLOCK_CSUM_EN
            r_csum     <= rx_data;
`endif
          end
          ST_PAYLOAD: begin
            r_byte_cnt <= r_byte_cnt + 6'd1;
            r_pack     <= {r_pack[15:0], rx_data};
`ifdef BLOCK_CSUM_EN
            r_csum     <= r_csum ^ rx_data;
`endif
          end
          default: ;
        endcase
      end

      if (w_sof)                            r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop)  r_ovf <= 1'b1;
    end
  end

  sync_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_din),
    .i_pop   (w_pop),
    .o_data  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign word_valid     = !w_empty;
  assign word_sob       = w_dout[34];
  assign word_init      = w_dout[33];
  assign word_eob       = w_dout[32];
  assign word_data      = w_dout[31:0];
  assign blk_done       = w_done;
  assign blk_err        = w_err;
  assign ovf            = r_ovf;
  assign dbg_state      = r_state;
  assign dbg_fifo_count = w_count;

endmodule

// File: tb/tb_uart_block_assembler.sv
module tb_uart_block_assembler;

  localparam int DEPTH = 4;
  localparam int TO    = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        word_sob;
  logic        word_init;
  logic        word_eob;
  logic        blk_done;
  logic        blk_err;
  logic        ovf;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_fifo_count;

  uart_block_assembler #(
    .SOF_BYTE    (8'hA5),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_sob       (word_sob),
    .word_init      (word_init),
    .word_eob       (word_eob),
    .blk_done       (blk_done),
    .blk_err        (blk_err),
    .ovf            (ovf),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard state
  logic [34:0] exp_q[$];
  bit          exp_ovf     = 0;
  int          done_cnt    = 0;
  int          err_cnt     = 0;
  bit          pend_valid  = 0;
  logic [34:0] pend_word;
  bit          ready_rand  = 0;
  bit          ready_hold  = 0;
  logic [7:0]  pl [64];

  // Expected entry for word w of the current payload: {sob, init, eob, data}
  function automatic logic [34:0] word_of(input int w, input bit init);
    word_of = {(w == 0), init, (w == 15), pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]};
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] cmd);
    logic [7:0] x;
    x = cmd;
    for (int i = 0; i < 64; i++) x = x ^ pl[i];
    return x;
  endfunction

  // consumer ready driver
  initial begin
    word_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      word_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_hold;
    end
  end

  // monitor / scoreboard: samples on the falling edge; a transfer seen here
  // happens at the following rising edge.
  initial begin
    bit          hold_prev;
    logic [34:0] held;
    logic [34:0] cur;
    hold_prev = 0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
      end else begin
        cur = {word_sob, word_init, word_eob, word_data};
        if (blk_done) done_cnt++;
        if (blk_err)  err_cnt++;
        if (hold_prev) begin
          check("hold_valid", 64'(word_valid), 64'd1);
          check("hold_word", 64'(cur), 64'(held));
        end
        if (word_valid && word_ready) begin
          if (exp_q.size() == 0) check("spurious_word", 64'(exp_q.size()), 64'd1);
          else                   check("word", 64'(cur), 64'(exp_q.pop_front()));
        end
        hold_prev = word_valid && !word_ready;
        held      = cur;
        if (pend_valid) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(pend_word);
          else                      exp_ovf = 1;
          pend_valid = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit push, input logic [34:0] w);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    if (push) begin
      pend_word  = w;
      pend_valid = 1;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_payload(input int nbytes, input bit init);
    for (int i = 0; i < nbytes; i++)
      send_byte(pl[i], (i % 4) == 3, word_of(i / 4, init));
  endtask

  task automatic send_body(input logic [7:0] cmd, input bit bad_csum);
    send_byte(cmd, 0, '0);
    send_payload(64, cmd[0]);
`ifdef BLOCK_CSUM_EN
    send_byte(bad_csum ? (csum_of(cmd) ^ 8'h01) : csum_of(cmd), 0, '0);
`else
    if (bad_csum) $display("note: checksum feature not built, frame sent without CSUM");
`endif
  endtask

  task automatic send_sof();
    send_byte(8'hA5, 0, '0);
    exp_ovf = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom_range(0, 255));
    pl[$urandom_range(0, 63)] = 8'hA5;
  endtask

  task automatic frame_end_check(input string tag, input int b_done, input int b_err,
                                 input int e_done, input int e_err);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 64'(done_cnt - b_done), 64'(e_done));
    check({tag, "_err"},  64'(err_cnt - b_err),   64'(e_err));
    check({tag, "_ovf"},  64'(ovf),               64'(exp_ovf));
  endtask

  task automatic drain(input string tag);
    ready_rand = 0;
    ready_hold = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({tag, "_drain_q"},     64'(exp_q.size()), 64'd0);
    check({tag, "_drain_valid"}, 64'(word_valid),   64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done;
    int b_err;
    logic [7:0] cmd;

    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_data",  64'(word_data),  64'd0);
    check("rst_flags", 64'({word_sob, word_init, word_eob}), 64'd0);
    check("rst_done",  64'(blk_done),   64'd0);
    check("rst_err",   64'(blk_err),    64'd0);
    check("rst_ovf",   64'(ovf),        64'd0);
    check("rst_state", 64'(dbg_state),  64'd0);
    check("rst_count", 64'(dbg_fifo_count), 64'd0);
    rst = 1'b0;

    // Incrementing payload, INIT set, consumer always ready
    for (int i = 0; i < 64; i++) pl[i] = 8'(i);
    ready_hold = 1;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_body(8'h01, 0);
    drain("incr");
    frame_end_check("incr", b_done, b_err, 1, 0);

    // Leading junk ignored, INIT clear, random consumer
    rand_payload();
    ready_rand = 1;
    b_done = done_cnt; b_err = err_cnt;
    send_byte(8'h00, 0, '0);
    send_byte(8'hFF, 0, '0);
    send_sof();
    send_body(8'h00, 0);
    drain("junk");
    frame_end_check("junk", b_done, b_err, 1, 0);

    // Consumer stalled for a whole frame: 4 held words, overflow
    rand_payload();
    ready_rand = 0;
    ready_hold = 0;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_body(8'h01, 0);
    frame_end_check("stall", b_done, b_err, 1, 0);
    check("stall_ovf_set", 64'(ovf), 64'd1);
    check("stall_count",   64'(dbg_fifo_count), 64'(DEPTH));
    drain("stall");
    check("ovf_sticky", 64'(ovf), 64'd1);
    rand_payload();
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    @(negedge clk);
    check("ovf_cleared_by_sof", 64'(ovf), 64'd0);
    send_body(8'hFE, 0);
    drain("after_ovf");
    frame_end_check("after_ovf", b_done, b_err, 1, 0);

    // Timeout after 10 payload bytes: 2 words kept, partial word discarded
    rand_payload();
    ready_hold = 0;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_byte(8'h01, 0, '0);
    send_payload(10, 1);
    repeat (TO + 20) @(negedge clk);
    check("to_err",   64'(err_cnt - b_err),   64'd1);
    check("to_done",  64'(done_cnt - b_done), 64'd0);
    check("to_count", 64'(dbg_fifo_count),    64'd2);
    check("to_state", 64'(dbg_state),         64'd0);
    drain("to");
    rand_payload();
    ready_rand = 1;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_body(8'h03, 0);
    drain("after_to");
    frame_end_check("after_to", b_done, b_err, 1, 0);

    // Reset while payload byte 30 is on the bus
    rand_payload();
    ready_rand = 0;
    ready_hold = 0;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_byte(8'h01, 0, '0);
    send_payload(30, 1);
    @(posedge clk);
    #1;
    rx_data  = pl[30];
    rx_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(word_valid),     64'd0);
    check("rst_mid_count", 64'(dbg_fifo_count), 64'd0);
    check("rst_mid_done",  64'(blk_done),       64'd0);
    check("rst_mid_ovf",   64'(ovf),            64'd0);
    check("rst_mid_state", 64'(dbg_state),      64'd0);
    rx_valid = 1'b0;
    exp_q.delete();
    pend_valid = 0;
    exp_ovf    = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_no_done", 64'(done_cnt - b_done), 64'd0);
    rand_payload();
    ready_rand = 1;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_body(8'h01, 0);
    drain("after_rst");
    frame_end_check("after_rst", b_done, b_err, 1, 0);

`ifdef BLOCK_CSUM_EN
    // Corrupted checksum: words still delivered, error only
    rand_payload();
    ready_rand = 1;
    b_done = done_cnt; b_err = err_cnt;
    send_sof();
    send_body(8'h01, 1);
    drain("bad_csum");
    frame_end_check("bad_csum", b_done, b_err, 0, 1);
`endif

    // Random frames, random consumer
    for (int f = 0; f < 3; f++) begin
      rand_payload();
      cmd = 8'($urandom_range(0, 255));
      ready_rand = 1;
      b_done = done_cnt; b_err = err_cnt;
      send_sof();
      send_body(cmd, 0);
      drain("rand");
      frame_end_check("rand", b_done, b_err, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
